// File: rtl/cl_scheduler.sv
// Purpose: control-loop table sequencer (periodic update strobe, 3-word velocity drain) plus
//          round-robin merge of two target-write requesters onto the single table write port.
// Latency: writes granted combinationally (zero cycles); tbl_update one cycle after the tick;
//          velocity words follow from the next cycle on.
// Backpressure: vel_ready low holds the current velocity word stable, and ticks that arrive
//               during that stall are dropped and flagged in overrun. Writes are never stalled
//               when they win arbitration.
// Ports: clk/N_reset; enable/period (tick timing); clear_flags; a_*/b_* write requesters;
//        tbl_* table write/update/read port; vel_* velocity stream; overrun/bad_axis sticky flags.
module cl_scheduler #(
    parameter int DATA_W   = 32,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                N_reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clear_flags,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [1:0]          a_axis,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [1:0]          b_axis,
    input  logic [DATA_W-1:0]   b_data,
    output logic                tbl_update,
    output logic                tbl_we,
    output logic [1:0]          tbl_wa,
    output logic [DATA_W-1:0]   tbl_wd,
    output logic [1:0]          tbl_ra,
    input  logic [DATA_W-1:0]   tbl_rd,
    output logic                vel_valid,
    input  logic                vel_ready,
    output logic [1:0]          vel_axis,
    output logic [DATA_W-1:0]   vel_data,
    output logic                overrun,
    output logic                bad_axis
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          axis_q, axis_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                rr_q, rr_d;        // 0: A wins a tie, 1: B wins a tie
    logic                overrun_q, overrun_d;
    logic                bad_q, bad_d;

    logic                tick;
    logic                grant_a, grant_b;
    logic                bad_set, overrun_set;

    // Tick counter: held at period while disabled so the first enabled interval is full length.
    always_comb begin
        tick  = enable && (cnt_q == '0);
        cnt_d = cnt_q - PERIOD_W'(1);
        if (!enable || tick) begin
            cnt_d = period;
        end
    end

    // Sequencer: WAIT -> UPDATE (one strobe) -> DRAIN axis 0,1,2 -> WAIT.
    always_comb begin
        state_d    = state_q;
        axis_d     = axis_q;
        tbl_update = 1'b0;
        vel_valid  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (tick) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                tbl_update = 1'b1;
                state_d    = ST_DRAIN;
                axis_d     = 2'd0;
            end
            ST_DRAIN: begin
                vel_valid = 1'b1;
                if (vel_ready) begin
                    if (axis_q == 2'd2) begin
                        state_d = ST_WAIT;
                        axis_d  = 2'd0;
                    end else begin
                        axis_d = axis_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT;
                axis_d  = 2'd0;
            end
        endcase
    end

    // axis_q is only non-zero while draining, so it can drive the read address directly.
    assign tbl_ra   = axis_q;
    assign vel_axis = axis_q;
    assign vel_data = vel_valid ? tbl_rd : '0;

    // Write arbitration: a lone requester always wins; on a tie the rr pointer decides.
    always_comb begin
        grant_a = a_valid && (!b_valid || !rr_q);
        grant_b = b_valid && (!a_valid ||  rr_q);
        a_ready = grant_a;
        b_ready = grant_b;
        tbl_we  = 1'b0;
        tbl_wa  = 2'd0;
        tbl_wd  = '0;
        bad_set = 1'b0;
        rr_d    = rr_q;
        if (grant_a) begin
            tbl_wa  = a_axis;
            tbl_wd  = a_data;
            tbl_we  = (a_axis != 2'd3);
            bad_set = (a_axis == 2'd3);
            rr_d    = 1'b1;
        end else if (grant_b) begin
            tbl_wa  = b_axis;
            tbl_wd  = b_data;
            tbl_we  = (b_axis != 2'd3);
            bad_set = (b_axis == 2'd3);
            rr_d    = 1'b0;
        end
    end

    // Sticky flags: a set in the same cycle as clear_flags wins.
    always_comb begin
        overrun_set = tick && (state_q != ST_WAIT);
        overrun_d   = overrun_set || (overrun_q && !clear_flags);
        bad_d       = bad_set     || (bad_q     && !clear_flags);
    end

    assign overrun  = overrun_q;
    assign bad_axis = bad_q;

    always_ff @(posedge clk or negedge N_reset) begin
        if (!N_reset) begin
            state_q   <= ST_WAIT;
            axis_q    <= 2'd0;
            cnt_q     <= '0;
            rr_q      <= 1'b0;
            overrun_q <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            axis_q    <= axis_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            overrun_q <= overrun_d;
            bad_q     <= bad_d;
        end
    end

endmodule

// File: tb/tb_cl_scheduler.sv
// Bench for cl_scheduler: a behavioural table drives tbl_rd, and a queue-based reference model
// predicts every output each cycle from the scheduling and arbitration rules.
module tb_cl_scheduler;

    localparam int DW = 32;
    localparam int PW = 16;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          N_reset, enable, clear_flags;
    logic [PW-1:0] period;
    logic          a_valid, b_valid, vel_ready;
    logic [1:0]    a_axis, b_axis;
    logic [DW-1:0] a_data, b_data;

    logic          a_ready, b_ready, tbl_update, tbl_we, vel_valid, overrun, bad_axis;
    logic [1:0]    tbl_wa, tbl_ra, vel_axis;
    logic [DW-1:0] tbl_wd, tbl_rd, vel_data;

    cl_scheduler #(.DATA_W(DW), .PERIOD_W(PW)) dut (
        .clk(clk), .N_reset(N_reset), .enable(enable), .period(period),
        .clear_flags(clear_flags),
        .a_valid(a_valid), .a_ready(a_ready), .a_axis(a_axis), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_axis(b_axis), .b_data(b_data),
        .tbl_update(tbl_update), .tbl_we(tbl_we), .tbl_wa(tbl_wa), .tbl_wd(tbl_wd),
        .tbl_ra(tbl_ra), .tbl_rd(tbl_rd),
        .vel_valid(vel_valid), .vel_ready(vel_ready), .vel_axis(vel_axis), .vel_data(vel_data),
        .overrun(overrun), .bad_axis(bad_axis)
    );

    // Control-loop table: velocity = new target - previous current, computed on update.
    logic [DW-1:0] t_tgt [4];
    logic [DW-1:0] t_cur [4];
    logic [DW-1:0] t_vel [4];

    always @(posedge clk) begin
        if (tbl_update) begin
            for (int i = 0; i < 3; i++) begin
                t_vel[i] <= t_tgt[i] - t_cur[i];
                t_cur[i] <= t_tgt[i];
            end
        end
        if (tbl_we) t_tgt[tbl_wa] <= tbl_wd;
    end

    assign tbl_rd = t_vel[tbl_ra];

    // Reference model state.
    typedef struct packed {
        logic [1:0]    ax;
        logic [DW-1:0] d;
    } vw_t;

    vw_t           vq[$];         // velocity words still owed to the consumer
    int            m_cnt;         // cycles until next tick
    bit            m_upd;         // update strobe due this cycle
    bit            m_prefb;       // B wins the next tie
    bit            m_ovr, m_bad;
    logic [DW-1:0] m_tgt [4];
    logic [DW-1:0] m_cur [4];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        vq.delete();
        m_cnt   = 0;
        m_upd   = 1'b0;
        m_prefb = 1'b0;
        m_ovr   = 1'b0;
        m_bad   = 1'b0;
    endtask

    // Called just after a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        bit ga, gb, tick, busy, bad_hit;
        vw_t w;
        #1;
        ga = a_valid && (!b_valid || !m_prefb);
        gb = b_valid && (!a_valid ||  m_prefb);
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        chk("tbl_we", tbl_we, (ga && a_axis != 2'd3) || (gb && b_axis != 2'd3));
        if (ga && a_axis != 2'd3) begin
            chk("tbl_wa", tbl_wa, a_axis);
            chk("tbl_wd", tbl_wd, a_data);
        end else if (gb && b_axis != 2'd3) begin
            chk("tbl_wa", tbl_wa, b_axis);
            chk("tbl_wd", tbl_wd, b_data);
        end
        chk("tbl_update", tbl_update, m_upd);
        chk("vel_valid", vel_valid, vq.size() != 0);
        if (vq.size() != 0) begin
            chk("vel_axis", vel_axis, vq[0].ax);
            chk("vel_data", vel_data, vq[0].d);
        end
        chk("overrun", overrun, m_ovr);
        chk("bad_axis", bad_axis, m_bad);

        // advance the model across the rising edge
        tick    = enable && (m_cnt == 0);
        busy    = m_upd || (vq.size() != 0);
        bad_hit = (ga && a_axis == 2'd3) || (gb && b_axis == 2'd3);
        if (!enable || tick) m_cnt = int'(period);
        else                 m_cnt = m_cnt - 1;
        if (m_upd) begin
            for (int i = 0; i < 3; i++) begin
                w.ax = 2'(i);
                w.d  = m_tgt[i] - m_cur[i];
                vq.push_back(w);
                m_cur[i] = m_tgt[i];
            end
            m_upd = 1'b0;
        end else if (vq.size() != 0 && vel_ready) begin
            void'(vq.pop_front());
        end
        if (clear_flags) begin
            m_ovr = 1'b0;
            m_bad = 1'b0;
        end
        if (tick) begin
            if (busy) m_ovr = 1'b1;
            else      m_upd = 1'b1;
        end
        if (bad_hit) m_bad = 1'b1;
        if (ga) begin
            if (a_axis != 2'd3) m_tgt[a_axis] = a_data;
            m_prefb = 1'b1;
        end else if (gb) begin
            if (b_axis != 2'd3) m_tgt[b_axis] = b_data;
            m_prefb = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_valid     = 1'b0;
        b_valid     = 1'b0;
        a_axis      = 2'd0;
        b_axis      = 2'd0;
        a_data      = '0;
        b_data      = '0;
        clear_flags = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            t_tgt[i] = '0; t_cur[i] = '0; t_vel[i] = '0;
            m_tgt[i] = '0; m_cur[i] = '0;
        end
        N_reset   = 1'b0;
        enable    = 1'b0;
        period    = PW'(4);
        vel_ready = 1'b0;
        idle_inputs();
        model_reset();

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_tbl_update", tbl_update, 1'b0);
        chk("rst_vel_valid", vel_valid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_bad_axis", bad_axis, 1'b0);
        chk("rst_tbl_we", tbl_we, 1'b0);
        @(negedge clk);
        N_reset = 1'b1;

        // 1: period 4, free-running drain
        enable    = 1'b1;
        period    = PW'(4);
        vel_ready = 1'b1;
        repeat (20) step();

        // 2: both requesters every cycle, alternating grants
        a_valid = 1'b1; a_axis = 2'd0; a_data = 32'h10;
        b_valid = 1'b1; b_axis = 2'd1; b_data = 32'h20;
        repeat (6) step();
        idle_inputs();

        // 3: target0 = 100 then 250 across two updates
        a_valid = 1'b1; a_axis = 2'd0; a_data = 32'd100;
        step();
        idle_inputs();
        repeat (6) step();
        a_valid = 1'b1; a_axis = 2'd0; a_data = 32'd250;
        step();
        idle_inputs();
        repeat (8) step();

        // 4: consumer stalls long enough for ticks to overrun
        period    = PW'(2);
        vel_ready = 1'b0;
        repeat (12) step();
        vel_ready = 1'b1;
        repeat (10) step();

        // 5: axis 3 write is accepted and dropped, then flags cleared
        b_valid = 1'b1; b_axis = 2'd3; b_data = 32'h5;
        step();
        idle_inputs();
        step();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        step();

        // 6: asynchronous reset while draining axis 1
        period    = PW'(3);
        vel_ready = 1'b0;
        for (int i = 0; i < 40 && vq.size() != 2; i++) begin
            vel_ready = (vq.size() == 3);
            step();
        end
        vel_ready = 1'b0;
        chk("t6_reached_axis1", vq.size(), 2);
        #2;
        N_reset = 1'b0;
        #1;
        chk("t6_async_vel_valid", vel_valid, 1'b0);
        chk("t6_async_tbl_update", tbl_update, 1'b0);
        model_reset();
        @(negedge clk);
        N_reset   = 1'b1;
        vel_ready = 1'b1;
        repeat (12) step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            enable      = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 49) == 0) period = PW'($urandom_range(0, 6));
            a_valid     = $urandom_range(0, 1) == 1;
            b_valid     = $urandom_range(0, 1) == 1;
            a_axis      = 2'($urandom_range(0, 3));
            b_axis      = 2'($urandom_range(0, 3));
            a_data      = $urandom;
            b_data      = $urandom;
            vel_ready   = ($urandom_range(0, 3) != 0);
            clear_flags = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
